fifo_stream_reader: RTL and testbench

- Read-side controller for the Synchronous_FIFO: drains the FIFO through its r_en/data_out/empty interface and presents the words as a valid/ready stream.
- Hides the FIFO's 1-cycle read latency with a 2-entry output skid buffer. Sustains one word per cycle with no loss under backpressure.
- Tags packet boundaries with m_last every PKT_LEN beats. Keeps a running delivered-word count.

---
 rtl/fifo_stream_reader.sv | 154 +++++++++++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side controller for Synchronous_FIFO: drains r_en/data_out into a valid/ready stream with m_last per packet (optional m_parity via STREAM_PARITY_EN).
// Latency: word read at edge k is on m_data after edge k+1; sustains one word per cycle.
// Backpressure: 2-entry skid buffer with credit-gated reads; outputs hold stable while m_valid && !m_ready.
module fifo_stream_reader #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
`ifdef STREAM_PARITY_EN
  output logic              m_parity,
`endif
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_e;

  buf_state_e        state_q, state_d;
  logic              inflight_q;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              last_q, last_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop;
  logic [1:0]        buf_cnt, occ;

  assign push    = inflight_q;
  assign m_valid = (state_q != S_EMPTY);
  assign pop     = m_valid && m_ready;
  assign buf_cnt = state_q;
  assign occ     = buf_cnt + {1'b0, inflight_q};

  // A pop this edge frees one slot, so a read may issue against it.
  assign fifo_r_en = rst && en && !fifo_empty && (pop ? (occ < 2'd3) : (occ < 2'd2));

  assign m_data   = head_q;
  assign m_last   = last_q;
  assign word_cnt = cnt_q;

`ifdef STREAM_PARITY_EN
  logic head_par_q, head_par_d;
  logic tail_par_q, tail_par_d;

  assign m_parity = head_par_q;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
`ifdef STREAM_PARITY_EN
    head_par_d = head_par_q;
    tail_par_d = tail_par_q;
`endif
    if (pop) begin
      cnt_d  = cnt_q + 1'b1;
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_d  = fifo_data;
          state_d = S_ONE;
`ifdef STREAM_PARITY_EN
          head_par_d = ^fifo_data;
`endif
        end
      end
      S_ONE: begin
        if (push && !pop) begin
          tail_d  = fifo_data;
          state_d = S_TWO;
`ifdef STREAM_PARITY_EN
          tail_par_d = ^fifo_data;
`endif
        end else if (!push && pop) begin
          state_d = S_EMPTY;
        end else if (push && pop) begin
          head_d = fifo_data;
`ifdef STREAM_PARITY_EN
          head_par_d = ^fifo_data;
`endif
        end
      end
      S_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = S_ONE;
`ifdef STREAM_PARITY_EN
          head_par_d = tail_par_q;
`endif
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Head beat index always equals the beat counter, so decode from its next value.
    last_d = (state_d != S_EMPTY) && (beat_d == LAST_BEAT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      last_q     <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_r_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef STREAM_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_par_q <= 1'b0;
      tail_par_q <= 1'b0;
    end else begin
      head_par_q <= head_par_d;
      tail_par_q <= tail_par_d;
    end
  end
`endif

  // The read credit rule must never let a word land while both entries are full.
  assert property (@(posedge clk) disable iff (!rst) !(state_q == S_TWO && inflight_q));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO plus an index-based word scoreboard.
module tb_fifo_stream_reader;
  localparam int DATA_W  = 8;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_r_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [CNT_W-1:0]  word_cnt;
`ifdef STREAM_PARITY_EN
  logic              m_parity;
`endif

  logic [DATA_W-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int total = 0;
  int bad = 0;
  int reads, delivered, exp_idx, cyc, first_dlv, last_dlv, lasts_seen, rd_at_reset;
  logic [CNT_W-1:0]  model_cnt;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  fifo_stream_reader #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
`ifdef STREAM_PARITY_EN
    .m_parity   (m_parity),
`endif
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural Synchronous_FIFO read port: data_out valid the cycle after r_en.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= mem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [DATA_W-1:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr++;
  endtask

  // Called at a falling edge with inputs already set; checks, then advances one cycle.
  task automatic tick();
    #1;
    cyc++;
    chk("rd_while_empty", {31'd0, fifo_r_en & fifo_empty}, 32'd0);
    if (fifo_r_en) reads++;
    chk("word_cnt", {16'd0, word_cnt}, {16'd0, model_cnt});
    if (prev_stall) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
      chk("hold_last", {31'd0, m_last}, {31'd0, prev_last});
    end
    if (m_valid && m_ready) begin
      if (exp_idx < wr_ptr) begin
        chk("data", {24'd0, m_data}, {24'd0, mem[exp_idx[11:0]]});
        chk("last", {31'd0, m_last}, {31'd0, ((delivered % PKT_LEN) == PKT_LEN - 1)});
`ifdef STREAM_PARITY_EN
        chk("parity", {31'd0, m_parity}, {31'd0, ^mem[exp_idx[11:0]]});
`endif
        exp_idx++;
      end else begin
        chk("spurious_valid", {31'd0, m_valid}, 32'd0);
      end
      if (m_last) lasts_seen++;
      if (delivered == 0) first_dlv = cyc;
      last_dlv = cyc;
      delivered++;
      model_cnt = model_cnt + 1'b1;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_ren", {31'd0, fifo_r_en}, 32'd0);
`ifdef STREAM_PARITY_EN
    chk("rst_parity", {31'd0, m_parity}, 32'd0);
`endif
    en = 1'b0;
    m_ready = 1'b0;
    exp_idx = rd_ptr;
    delivered = 0;
    model_cnt = '0;
    prev_stall = 1'b0;
    lasts_seen = 0;
    reads = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until(input int n, input int bound, input string tag, input bit toggle);
    int k = 0;
    while (delivered < n && k < bound) begin
      if (toggle) m_ready = (k % 2 == 0);
      tick();
      k++;
    end
    chk(tag, delivered, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    cyc = 0;
    @(negedge clk);
    apply_reset();

    // Back-to-back drain of a 4-word packet.
    put_word(8'd10); put_word(8'd20); put_word(8'd30); put_word(8'd40);
    en = 1'b1; m_ready = 1'b1;
    run_until(4, 20, "s1_delivered", 1'b0);
    chk("s1_span", last_dlv - first_dlv, 32'd3);
    chk("s1_reads", reads, 32'd4);
    chk("s1_lasts", lasts_seen, 32'd1);
    chk("s1_word_cnt", {16'd0, word_cnt}, 32'd4);

    // Full backpressure: only two reads may issue, head holds the first word.
    apply_reset();
    put_word(8'd10); put_word(8'd20); put_word(8'd30); put_word(8'd40);
    en = 1'b1; m_ready = 1'b0;
    repeat (6) tick();
    chk("s2_reads", reads, 32'd2);
    chk("s2_valid", {31'd0, m_valid}, 32'd1);
    chk("s2_head", {24'd0, m_data}, 32'd10);
    m_ready = 1'b1;
    run_until(4, 20, "s2_delivered", 1'b0);
    chk("s2_reads_total", reads, 32'd4);
    chk("s2_drained", exp_idx, wr_ptr);

    // Empty FIFO: nothing may be read or presented.
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("s3_ren", {31'd0, fifo_r_en}, 32'd0);
      chk("s3_valid", {31'd0, m_valid}, 32'd0);
      tick();
    end

    // Alternating ready over two packets.
    apply_reset();
    for (int i = 1; i <= 8; i++) put_word(DATA_W'(i));
    en = 1'b1;
    run_until(8, 40, "s4_delivered", 1'b1);
    chk("s4_lasts", lasts_seen, 32'd2);
    chk("s4_word_cnt", {16'd0, word_cnt}, 32'd8);

    // Reset mid-stream; read-ahead words are discarded, beat count restarts.
    apply_reset();
    for (int i = 0; i < 8; i++) put_word(DATA_W'(8'h50 + i));
    en = 1'b1; m_ready = 1'b1;
    run_until(2, 20, "s5_pre", 1'b0);
    apply_reset();
    rd_at_reset = rd_ptr;
    en = 1'b1; m_ready = 1'b1;
    run_until(wr_ptr - rd_at_reset, 30, "s5_post", 1'b0);
    chk("s5_word_cnt", {16'd0, word_cnt}, wr_ptr - rd_at_reset);

    // Parity corner words for the optional output.
    apply_reset();
    put_word(8'h07); put_word(8'h03); put_word(8'hff); put_word(8'h80);
    en = 1'b1; m_ready = 1'b1;
    run_until(4, 20, "s6_delivered", 1'b0);

    // Randomized traffic against the scoreboard.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ((wr_ptr - rd_ptr) < 12 && $urandom_range(2) == 0) put_word(DATA_W'($urandom));
      en = ($urandom_range(7) != 0);
      m_ready = ($urandom_range(2) != 0);
      tick();
    end
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 100 && exp_idx < wr_ptr; i++) tick();
    chk("rand_drained", exp_idx, wr_ptr);
    chk("rand_word_cnt", {16'd0, word_cnt}, delivered);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
